// File: rtl/exc_scheduler_pkg.sv
// Shared exception-scheduler definitions: exccodes, flag bit positions, CP0 field positions.
package exc_scheduler_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam int EXC_BIT_IF_ADEL = 0;
  localparam int EXC_BIT_RI      = 1;
  localparam int EXC_BIT_OV      = 2;
  localparam int EXC_BIT_SYS     = 3;
  localparam int EXC_BIT_BP      = 4;
  localparam int EXC_BIT_ERET    = 5;
  localparam int EXC_BIT_D_ADEL  = 6;
  localparam int EXC_BIT_D_ADES  = 7;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;

  typedef enum logic [1:0] {
    BAD_ZERO,
    BAD_PC,
    BAD_ADDR
  } bad_sel_t;

  typedef enum logic {
    ST_IDLE,
    ST_BLANK
  } sched_state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed MIPS priority encoder: {int_pending, mem_exc} -> exccode and bad-address source.
module exc_prio_enc
  import exc_scheduler_pkg::*;
(
  input  logic       int_pending,
  input  logic [7:0] mem_exc,
  output logic [4:0] exccode,
  output bad_sel_t   bad_sel
);

  always_comb begin
    exccode = EXC_NONE;
    bad_sel = BAD_ZERO;
    if (int_pending) begin
      exccode = EXC_INT;
    end else if (mem_exc[EXC_BIT_IF_ADEL]) begin
      exccode = EXC_ADEL;
      bad_sel = BAD_PC;
    end else if (mem_exc[EXC_BIT_RI]) begin
      exccode = EXC_RI;
    end else if (mem_exc[EXC_BIT_OV]) begin
      exccode = EXC_OV;
    end else if (mem_exc[EXC_BIT_SYS]) begin
      exccode = EXC_SYS;
    end else if (mem_exc[EXC_BIT_BP]) begin
      exccode = EXC_BP;
    end else if (mem_exc[EXC_BIT_ERET]) begin
      exccode = EXC_ERET;
    end else if (mem_exc[EXC_BIT_D_ADEL]) begin
      exccode = EXC_ADEL;
      bad_sel = BAD_ADDR;
    end else if (mem_exc[EXC_BIT_D_ADES]) begin
      exccode = EXC_ADES;
      bad_sel = BAD_ADDR;
    end
  end

endmodule

// File: rtl/exc_scheduler.sv
// Exception/interrupt scheduler between MEM and CP0 with a post-event blanking window.
// EXC_SCHED_IRQ_SYNC_EN: when defined, hw_int_i passes a two-flop synchronizer (else one register).
module exc_scheduler
  import exc_scheduler_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int HW_INT_W     = 6
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst,
  input  logic [HW_INT_W-1:0] hw_int_i,
  output logic [HW_INT_W-1:0] int_o,
  input  logic [31:0]         status_i,
  input  logic [31:0]         cause_i,
  input  logic                mem_valid_i,
  input  logic [7:0]          mem_exc_i,
  input  logic [31:0]         mem_pc_i,
  input  logic                mem_in_delay_i,
  input  logic [31:0]         mem_addr_i,
  output logic [4:0]          exccode_o,
  output logic [31:0]         pc_o,
  output logic                in_delay_o,
  output logic [31:0]         badvaddr_o,
  output logic                blank_o
);

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  sched_state_t        state;
  logic [3:0]          cnt;
  logic [HW_INT_W-1:0] int_q;
  logic                int_pending;
  logic                take;
  logic [4:0]          enc_code;
  bad_sel_t            bad_sel;
  logic                unused_bits;

  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  assign int_pending = status_i[STATUS_IE] & ~status_i[STATUS_EXL] &
                       (|(cause_i[CAUSE_IP_HI:CAUSE_IP_LO] & status_i[STATUS_IM_HI:STATUS_IM_LO]));

  // Decode only for a real instruction in IDLE; reset forces the quiet output set.
  assign take = ~cpu_rst & (state == ST_IDLE) & mem_valid_i;

  exc_prio_enc u_prio_enc (
    .int_pending (int_pending),
    .mem_exc     (mem_exc_i),
    .exccode     (enc_code),
    .bad_sel     (bad_sel)
  );

  always_comb begin
    exccode_o  = EXC_NONE;
    pc_o       = '0;
    in_delay_o = 1'b0;
    badvaddr_o = '0;
    if (take && enc_code != EXC_NONE) begin
      exccode_o  = enc_code;
      pc_o       = mem_pc_i;
      in_delay_o = mem_in_delay_i;
      case (bad_sel)
        BAD_PC:   badvaddr_o = mem_pc_i;
        BAD_ADDR: badvaddr_o = mem_addr_i;
        default:  badvaddr_o = '0;
      endcase
    end
  end

  assign blank_o = ~cpu_rst & (state == ST_BLANK);
  assign int_o   = cpu_rst ? '0 : int_q;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (exccode_o != EXC_NONE) begin
            state <= ST_BLANK;
            cnt   <= CNT_LOAD;
          end
        end
        ST_BLANK: begin
          if (cnt == 4'd0) state <= ST_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef EXC_SCHED_IRQ_SYNC_EN
  logic [HW_INT_W-1:0] int_sync1;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      int_sync1 <= '0;
      int_q     <= '0;
    end else begin
      int_sync1 <= hw_int_i;
      int_q     <= int_sync1;
    end
  end
`else
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) int_q <= '0;
    else         int_q <= hw_int_i;
  end
`endif

endmodule

// File: tb/tb_exc_scheduler.sv
// Self-checking bench for exc_scheduler: directed table, corner sequences, random vs. reference model.
module tb_exc_scheduler;

  localparam int FLUSH = 2;
  localparam int HW_W  = 6;
`ifdef EXC_SCHED_IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [4:0] NONE = 5'h10;

  logic            clk;
  logic            rst;
  logic [HW_W-1:0] hw;
  logic [HW_W-1:0] int_o;
  logic [31:0]     status;
  logic [31:0]     cause;
  logic            valid;
  logic [7:0]      exc;
  logic [31:0]     pc;
  logic            dly;
  logic [31:0]     addr;
  logic [4:0]      exccode_o;
  logic [31:0]     pc_o;
  logic            in_delay_o;
  logic [31:0]     badvaddr_o;
  logic            blank_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: blank cycles still to come, and per-edge history of hw/reset.
  int              mdl_blank = 0;
  logic [HW_W-1:0] hw_hist[$];
  bit              rst_hist[$];

  exc_scheduler #(.FLUSH_CYCLES(FLUSH), .HW_INT_W(HW_W)) dut (
    .cpu_clk_50M    (clk),
    .cpu_rst        (rst),
    .hw_int_i       (hw),
    .int_o          (int_o),
    .status_i       (status),
    .cause_i        (cause),
    .mem_valid_i    (valid),
    .mem_exc_i      (exc),
    .mem_pc_i       (pc),
    .mem_in_delay_i (dly),
    .mem_addr_i     (addr),
    .exccode_o      (exccode_o),
    .pc_o           (pc_o),
    .in_delay_o     (in_delay_o),
    .badvaddr_o     (badvaddr_o),
    .blank_o        (blank_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Priority list walked in order; the first raised request wins.
  task automatic ref_event(output logic [4:0] code, output logic [31:0] bad);
    logic [4:0] codes[9];
    bit         req[9];
    bit         ip;
    codes = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h11, 5'h04, 5'h05};
    ip = status[0] && !status[1] && ((cause[15:8] & status[15:8]) != 8'h00);
    req[0] = ip;
    for (int i = 0; i < 8; i++) req[i+1] = exc[i];
    code = NONE;
    bad  = 32'h0;
    for (int i = 0; i < 9; i++) begin
      if (req[i]) begin
        code = codes[i];
        if (i == 1) bad = pc;
        else if (i == 7 || i == 8) bad = addr;
        break;
      end
    end
  endtask

  task automatic cycle();
    logic [4:0]      e_code;
    logic [31:0]     e_bad;
    logic [HW_W-1:0] e_int;
    bit              any_rst;
    @(negedge clk);
    e_code = NONE;
    e_bad  = 32'h0;
    if (!rst && mdl_blank == 0 && valid) ref_event(e_code, e_bad);
    any_rst = rst;
    for (int i = 0; i < LAT; i++) any_rst |= rst_hist[i];
    e_int = any_rst ? '0 : hw_hist[LAT-1];
    chk("exccode", {27'h0, exccode_o}, {27'h0, e_code});
    chk("pc", pc_o, (e_code != NONE) ? pc : 32'h0);
    chk("in_delay", {31'h0, in_delay_o}, {31'h0, (e_code != NONE) ? dly : 1'b0});
    chk("badvaddr", badvaddr_o, e_bad);
    chk("blank", {31'h0, blank_o}, {31'h0, (!rst && mdl_blank > 0)});
    chk("int_o", {26'h0, int_o}, {26'h0, e_int});
    @(posedge clk);
    if (rst)                mdl_blank = 0;
    else if (mdl_blank > 0) mdl_blank--;
    else if (e_code != NONE) mdl_blank = FLUSH;
    hw_hist.push_front(hw);
    rst_hist.push_front(rst);
    void'(hw_hist.pop_back());
    void'(rst_hist.pop_back());
    #1;
  endtask

  task automatic drain();
    valid = 1'b0;
    exc   = 8'h00;
    for (int i = 0; i < 20 && mdl_blank > 0; i++) cycle();
  endtask

  typedef struct {
    logic [31:0] status;
    logic [31:0] cause;
    logic        valid;
    logic [7:0]  exc;
    logic [31:0] pc;
    logic        dly;
    logic [31:0] addr;
    logic [4:0]  exp_code;
    logic [31:0] exp_bad;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{32'h0, 32'h0, 1'b1, 8'h80, 32'h8000_2000, 1'b1, 32'h0000_0003, 5'h05, 32'h0000_0003};
    vecs[1]  = '{32'h401, 32'h400, 1'b1, 8'h08, 32'h8000_3000, 1'b0, 32'h0, 5'h00, 32'h0};
    vecs[2]  = '{32'h403, 32'h400, 1'b1, 8'h08, 32'h8000_3004, 1'b0, 32'h0, 5'h08, 32'h0};
    vecs[3]  = '{32'h0, 32'h0, 1'b1, 8'h01, 32'hbfc0_0006, 1'b0, 32'h1234, 5'h04, 32'hbfc0_0006};
    vecs[4]  = '{32'h0, 32'h0, 1'b1, 8'h40, 32'h8000_4000, 1'b1, 32'h0000_1001, 5'h04, 32'h0000_1001};
    vecs[5]  = '{32'h0, 32'h0, 1'b1, 8'h30, 32'h8000_5000, 1'b0, 32'h0, 5'h09, 32'h0};
    vecs[6]  = '{32'h0, 32'h0, 1'b1, 8'h20, 32'h8000_6000, 1'b0, 32'h0, 5'h11, 32'h0};
    vecs[7]  = '{32'h0, 32'h0, 1'b0, 8'hff, 32'h8000_7000, 1'b1, 32'h5, 5'h10, 32'h0};
    vecs[8]  = '{32'h0, 32'h0, 1'b1, 8'h00, 32'h8000_8000, 1'b0, 32'h0, 5'h10, 32'h0};
    vecs[9]  = '{32'h8001, 32'h8000, 1'b1, 8'h02, 32'h8000_9000, 1'b0, 32'h0, 5'h00, 32'h0};
    vecs[10] = '{32'h4001, 32'h8000, 1'b1, 8'h84, 32'h8000_a000, 1'b0, 32'h7, 5'h0c, 32'h0};

    for (int i = 0; i < LAT; i++) begin
      hw_hist.push_front('0);
      rst_hist.push_front(1'b1);
    end
    rst = 1'b1; hw = 6'h3f; status = 32'h0; cause = 32'h0;
    valid = 1'b0; exc = 8'h00; pc = 32'h0; dly = 1'b0; addr = 32'h0;

    // Reset with all interrupt lines high, then release and watch the lag.
    repeat (3) cycle();
    chk("int_o_in_reset", {26'h0, int_o}, 32'h0);
    rst = 1'b0;
    repeat (LAT) cycle();
    chk("int_o_release", {26'h0, int_o}, 32'h3f);

    // RI+OV: RI wins, then a SYS request inside the blank window is dropped.
    valid = 1'b1; exc = 8'h06; pc = 32'h8000_1000; dly = 1'b0; addr = 32'hdead_beef;
    #1;
    chk("ri_ov_code", {27'h0, exccode_o}, 32'h0a);
    chk("ri_ov_bad", badvaddr_o, 32'h0);
    cycle();
    exc = 8'h08;
    for (int i = 0; i < FLUSH; i++) begin
      #1;
      chk("blank_win", {31'h0, blank_o}, 32'h1);
      chk("blank_code", {27'h0, exccode_o}, 32'h10);
      cycle();
    end
    valid = 1'b0; exc = 8'h00;
    #1;
    chk("blank_end", {31'h0, blank_o}, 32'h0);
    cycle();

    // Directed table.
    for (int v = 0; v < 11; v++) begin
      status = vecs[v].status; cause = vecs[v].cause; valid = vecs[v].valid;
      exc = vecs[v].exc; pc = vecs[v].pc; dly = vecs[v].dly; addr = vecs[v].addr;
      #1;
      chk($sformatf("vec%0d_code", v), {27'h0, exccode_o}, {27'h0, vecs[v].exp_code});
      chk($sformatf("vec%0d_bad", v), badvaddr_o, vecs[v].exp_bad);
      cycle();
      drain();
      status = 32'h0; cause = 32'h0;
    end

    // Interrupt appearing mid-BLANK is taken on the first IDLE cycle.
    valid = 1'b1; exc = 8'h08; pc = 32'h8000_b000;
    cycle();
    status = 32'h401; cause = 32'h400; exc = 8'h00; pc = 32'h8000_b004;
    repeat (FLUSH) cycle();
    #1;
    chk("late_int_code", {27'h0, exccode_o}, 32'h00);
    chk("late_int_pc", pc_o, 32'h8000_b004);
    cycle();
    drain();
    status = 32'h0; cause = 32'h0;

    // ERET then reset on the first BLANK cycle.
    valid = 1'b1; exc = 8'h20; pc = 32'h8000_c000;
    #1;
    chk("eret_code", {27'h0, exccode_o}, 32'h11);
    cycle();
    rst = 1'b1;
    #1;
    chk("rst_blank", {31'h0, blank_o}, 32'h0);
    chk("rst_code", {27'h0, exccode_o}, 32'h10);
    cycle();
    rst = 1'b0; exc = 8'h08;
    #1;
    chk("post_rst_blank", {31'h0, blank_o}, 32'h0);
    chk("post_rst_code", {27'h0, exccode_o}, 32'h08);
    cycle();
    drain();

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      hw     = HW_W'($urandom);
      status = $urandom & 32'h0000_ff03;
      cause  = $urandom & 32'h0000_ff00;
      valid  = ($urandom_range(0, 3) != 0);
      exc    = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom);
      pc     = $urandom;
      dly    = 1'($urandom);
      addr   = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exc_scheduler.md
Name: exc_scheduler

Overview:
- Exception/interrupt scheduler sitting between the MEM stage and the CP0 register file.
- Each cycle it collects the exception flags of the instruction in MEM, the masked pending interrupts and the external hardware interrupt lines, and picks one event by fixed MIPS priority.
- It drives a single exccode, PC, delay-slot flag and bad address to CP0.
- After any committed event it enforces a blanking window so that instructions already being flushed cannot raise a second exception.

Parameters:
- FLUSH_CYCLES, 2, number of cycles after a committed event during which new exceptions and interrupts are ignored (range 1..15).
- HW_INT_W, 6, number of external hardware interrupt lines.

Ports:
- cpu_clk_50M  input  1  clock.
- cpu_rst  input  1  reset; synchronous, active-high.
- hw_int_i  input  HW_INT_W  raw external interrupt lines.
- int_o  output  HW_INT_W  registered interrupt lines, wired to the CP0 int_i / cause[15:10] input.
- status_i  input  32  CP0 status.
- cause_i  input  32  CP0 cause.
- mem_valid_i  input  1  MEM holds a real instruction, not a bubble.
- mem_exc_i  input  8  exception flags of the MEM instruction: [0] fetch AdEL, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] ERET, [6] data AdEL, [7] data AdES.
- mem_pc_i  input  32  PC of the MEM instruction.
- mem_in_delay_i  input  1  MEM instruction is in a delay slot.
- mem_addr_i  input  32  data address of the MEM load/store.
- exccode_o  output  5  to CP0 exccode_i.
- pc_o  output  32  to CP0 pc_i.
- in_delay_o  output  1  to CP0 in_delay_i.
- badvaddr_o  output  32  to CP0 badvaddr_i.
- blank_o  output  1  high while in the BLANK state.

Behaviour:
- Exccode constants (defines.v): INT 5'h00, ADEL 5'h04, ADES 5'h05, SYS 5'h08, BP 5'h09, RI 5'h0a, OV 5'h0c, NONE 5'h10, ERET 5'h11.
- int_pending = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
- The event request is decoded only when state == IDLE and mem_valid_i == 1; otherwise the request is NONE.
- Priority, highest first: INT, fetch AdEL, RI, OV, SYS, BP, ERET, data AdEL, data AdES.
- Output routing for the selected event:
  - exccode_o is combinational, zero-latency from the inputs.
  - pc_o = mem_pc_i and in_delay_o = mem_in_delay_i.
  - badvaddr_o = mem_pc_i for fetch AdEL; mem_addr_i for data AdEL/AdES; 0 otherwise.
- When no event is selected: exccode_o = NONE and pc_o / in_delay_o / badvaddr_o = 0.
- FSM has two states, IDLE and BLANK:
  - IDLE -> BLANK when exccode_o != NONE (ERET included). The counter loads FLUSH_CYCLES-1.
  - In BLANK, the counter decrements each cycle. At counter == 0 the next state is IDLE.
  - FLUSH_CYCLES=1 gives exactly one blank cycle.
- While in BLANK: exccode_o = NONE, blank_o = 1, and all inputs except hw_int_i are ignored.
- A pending interrupt that is masked by EXL during BLANK is taken in the first IDLE cycle in which it is unmasked and mem_valid_i is 1.
- Simultaneous interrupt and instruction exception: INT wins; the instruction is re-executed after ERET.
- mem_valid_i=0 with mem_exc_i != 0: ignored, exccode_o = NONE.
- Reset has priority over everything: state IDLE, counter 0, int_o 0, synchronizer flops 0. All outputs read as 0 or NONE during the reset cycle, including when reset arrives mid-BLANK.
- int_o is updated every cycle, including during BLANK.

Optional Feature:
- Macro EXC_SCHED_IRQ_SYNC_EN.
- Defined: hw_int_i passes through a two-flop synchronizer; int_o lags hw_int_i by 2 cycles.
- Undefined: a single register stage; int_o lags hw_int_i by 1 cycle.

Decomposition:
- defines.v holds: exccode constants, the mem_exc_i bit indices, and the status IE/EXL and cause IP/IM field positions.
- The cross-cutting definitions are added to the shared package.
- One sub-module, exc_prio_enc: purely combinational priority encoder from {int_pending, mem_exc_i} to exccode plus badvaddr select.
- The FSM, counter and synchronizer stay in exc_scheduler.

Test Plan:
- Reset with hw_int_i=6'h3f, then release. Required: int_o=0 during reset; int_o=6'h3f after 2 cycles (macro on) or 1 cycle (macro off).
- mem_valid_i=1, mem_exc_i=8'h06 (RI+OV), pc 0x80001000. Required: exccode 5'h0a, pc_o 0x80001000, badvaddr 0.
- Then blank_o=1 for 2 cycles with exccode NONE; a 5'h08 request in that window is dropped.
- Data AdES, mem_addr 0x00000003, in_delay=1. Required: exccode 5'h05, badvaddr 0x00000003, in_delay_o=1.
- status=0x0000_0401, cause IP2 set, and mem_exc_i=bit3 in the same cycle. Required: exccode 5'h00 (INT wins).
- Repeat with status=0x0000_0403 (EXL set). Required: exccode 5'h08.
- ERET committed, then reset asserted on the first BLANK cycle. Required: IDLE on the next cycle, exccode NONE, blank_o=0.
